// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the 5x5 convolution PE sequencer.
package pe_pkg;

    localparam int KNL_SIZE_DEF = 5;
    localparam int PIPE_LAT_DEF = 2;
    localparam int TAPS         = KNL_SIZE_DEF * KNL_SIZE_DEF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WAIT_OUT,
        FIN
    } state_e;

endpackage

// File: rtl/pe_conv_sched_if.sv
// Operand-read bus, accumulator strobes and window-result handshake of the PE sequencer.
interface pe_conv_sched_if #(
    parameter int DIM_W   = 8,
    parameter int ADDR_W  = 12,
    parameter int WADDR_W = 5
);
    logic               tap_valid;
    logic [ADDR_W-1:0]  pix_addr;
    logic [WADDR_W-1:0] wgt_addr;
    logic               acc_clr;
    logic               acc_en;
    logic               acc_last;
    logic               out_valid;
    logic               out_ready;
    logic [DIM_W-1:0]   out_row;
    logic [DIM_W-1:0]   out_col;

    modport master (
        output tap_valid, pix_addr, wgt_addr,
        output acc_clr, acc_en, acc_last,
        output out_valid, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  tap_valid, pix_addr, wgt_addr,
        input  acc_clr, acc_en, acc_last,
        input  out_valid, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/pe_strobe_delay.sv
// Purpose: aligns accumulator strobes {en, clr, last} with the read+multiply pipeline.
// Latency: exactly LAT cycles. Backpressure: none, free-running shift register.
module pe_strobe_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    input  logic last_i,
    output logic en_o,
    output logic clr_o,
    output logic last_o
);
    logic [2:0] pipe_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {en_i, clr_i, last_i};
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {en_o, clr_o, last_o} = pipe_q[LAT-1];

endmodule

// File: rtl/pe_conv_sched.sv
// Purpose: walks every valid 5x5 window, issuing one operand-read tap per cycle.
// Latency: first tap 1 cycle after start; K^2+PIPE_LAT+1 cycles per window.
// Backpressure: a stalled result (out_ready low) freezes the whole schedule.
module pe_conv_sched
    import pe_pkg::*;
#(
    parameter int KNL_SIZE = KNL_SIZE_DEF,
    parameter int DIM_W    = 8,
    parameter int ADDR_W   = 12,
    parameter int WADDR_W  = 5,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    pe_conv_sched_if.master  bus
);
    localparam int N_TAPS = KNL_SIZE * KNL_SIZE;
    localparam int KC_W   = (KNL_SIZE > 1) ? $clog2(KNL_SIZE) : 1;
    localparam int DRN_W  = $clog2(PIPE_LAT + 1);
    localparam int PROD_W = 2 * DIM_W + 1;

    localparam logic [DIM_W-1:0]   K_DIM    = DIM_W'(KNL_SIZE);
    localparam logic [KC_W-1:0]    KC_LAST  = KC_W'(KNL_SIZE - 1);
    localparam logic [WADDR_W-1:0] TAP_LAST = WADDR_W'(N_TAPS - 1);
    localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(PIPE_LAT - 1);
    localparam logic [PROD_W-1:0]  MAX_PIX  = PROD_W'(2 ** ADDR_W);

    state_e             state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]   orow_q, orow_d, ocol_q, ocol_d;
    logic [ADDR_W-1:0]  obase_q, obase_d;
    logic [ADDR_W-1:0]  roff_q, roff_d;
    logic [KC_W-1:0]    kc_q, kc_d;
    logic [WADDR_W-1:0] tap_q, tap_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               err_q, err_d;

    logic               tap_vld;
    logic [PROD_W-1:0]  prod;
    logic               cfg_bad;

    assign prod    = PROD_W'(img_w) * PROD_W'(img_h);
    assign cfg_bad = (img_w < K_DIM) || (img_h < K_DIM) || (prod > MAX_PIX);

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        obase_d   = obase_q;
        roff_d    = roff_q;
        kc_d      = kc_q;
        tap_d     = tap_q;
        drn_d     = drn_q;
        err_d     = err_q;
        tap_vld   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = img_w;
                    h_d     = img_h;
                    orow_d  = '0;
                    ocol_d  = '0;
                    obase_d = '0;
                    roff_d  = '0;
                    kc_d    = '0;
                    tap_d   = '0;
                    err_d   = cfg_bad;
                    state_d = cfg_bad ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                tap_vld = 1'b1;
                if (tap_q == TAP_LAST) begin
                    tap_d   = '0;
                    kc_d    = '0;
                    roff_d  = '0;
                    drn_d   = '0;
                    state_d = DRAIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                    // Row offset steps by one image row each time kc wraps.
                    if (kc_q == KC_LAST) begin
                        kc_d   = '0;
                        roff_d = roff_q + ADDR_W'(w_q);
                    end else begin
                        kc_d = kc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drn_q == DRN_LAST) state_d = WAIT_OUT;
                else                   drn_d   = drn_q + 1'b1;
            end
            WAIT_OUT: begin
                busy = 1'b1;
                if (bus.out_ready) begin
                    if (ocol_q == w_q - K_DIM) begin
                        ocol_d = '0;
                        if (orow_q == h_q - K_DIM) begin
                            orow_d  = '0;
                            obase_d = '0;
                            state_d = FIN;
                        end else begin
                            orow_d  = orow_q + 1'b1;
                            obase_d = obase_q + ADDR_W'(w_q);
                            state_d = ISSUE;
                        end
                    end else begin
                        ocol_d  = ocol_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            obase_q <= '0;
            roff_q  <= '0;
            kc_q    <= '0;
            tap_q   <= '0;
            drn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            obase_q <= obase_d;
            roff_q  <= roff_d;
            kc_q    <= kc_d;
            tap_q   <= tap_d;
            drn_q   <= drn_d;
            err_q   <= err_d;
        end
    end

    assign cfg_err       = err_q;
    assign bus.tap_valid = tap_vld;
    assign bus.pix_addr  = tap_vld ? (obase_q + ADDR_W'(ocol_q) + roff_q + ADDR_W'(kc_q)) : '0;
    assign bus.wgt_addr  = tap_vld ? tap_q : '0;
    assign bus.out_valid = (state_q == WAIT_OUT);
    assign bus.out_row   = orow_q;
    assign bus.out_col   = ocol_q;

    pe_strobe_delay #(
        .LAT (PIPE_LAT)
    ) u_strobe_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (tap_vld),
        .clr_i  (tap_vld && (tap_q == '0)),
        .last_i (tap_vld && (tap_q == TAP_LAST)),
        .en_o   (bus.acc_en),
        .clr_o  (bus.acc_clr),
        .last_o (bus.acc_last)
    );

endmodule

// File: tb/tb_pe_conv_sched.sv
// Bench for pe_conv_sched: transaction-level model of taps/results plus directed timing checks.
module tb_pe_conv_sched;
    import pe_pkg::*;

    localparam int K       = 5;
    localparam int NT      = TAPS;
    localparam int DIM_W   = 8;
    localparam int ADDR_W  = 12;
    localparam int WADDR_W = 5;
    localparam int PL      = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [DIM_W-1:0] img_w = '0;
    logic [DIM_W-1:0] img_h = '0;
    logic             busy, done, cfg_err;

    pe_conv_sched_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)) bus ();

    pe_conv_sched #(
        .KNL_SIZE (K),
        .DIM_W    (DIM_W),
        .ADDR_W   (ADDR_W),
        .WADDR_W  (WADDR_W),
        .PIPE_LAT (PL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .img_w   (img_w),
        .img_h   (img_h),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int exp_pix[$], exp_wgt[$], exp_row[$], exp_col[$];
    int win_first[$];
    int tap_cnt, res_cnt, done_cnt, hold_cnt;
    int first_tap_cyc, last_tap_cyc, first_clr_cyc, last_accl_cyc, done_cyc, start_cyc;
    logic cfg_at_done;
    logic [2:0] hist [PL];
    logic prev_hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    // Expected job content straight from the convolution definition.
    task automatic build_job(input int w, input int h);
        for (int r = 0; r <= h - K; r++) begin
            for (int c = 0; c <= w - K; c++) begin
                exp_row.push_back(r);
                exp_col.push_back(c);
                for (int kr = 0; kr < K; kr++) begin
                    for (int kc = 0; kc < K; kc++) begin
                        exp_pix.push_back((r + kr) * w + c + kc);
                        exp_wgt.push_back(kr * K + kc);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] cur;
        logic       nz;
        if (!rst_n) begin
            nz = busy | done | cfg_err | bus.tap_valid | bus.acc_en | bus.acc_clr | bus.acc_last |
                 bus.out_valid | (|bus.pix_addr) | (|bus.wgt_addr) | (|bus.out_row) | (|bus.out_col);
            chk("reset_outputs_zero", int'(nz), 0);
            exp_pix.delete(); exp_wgt.delete(); exp_row.delete(); exp_col.delete();
            for (int i = 0; i < PL; i++) hist[i] = '0;
            tap_cnt   = 0;
            prev_hold = 1'b0;
        end else begin
            cur = {bus.tap_valid,
                   bus.tap_valid && (tap_cnt % NT == 0),
                   bus.tap_valid && (tap_cnt % NT == NT - 1)};
            chk("acc_strobes", int'({bus.acc_en, bus.acc_clr, bus.acc_last}), int'(hist[PL-1]));
            for (int i = PL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
            if (bus.acc_clr && first_clr_cyc < 0) first_clr_cyc = cyc;
            if (bus.acc_last) last_accl_cyc = cyc;

            if (bus.tap_valid) begin
                chk("no_tap_while_out_valid", int'(bus.out_valid), 0);
                if (exp_pix.size() == 0) begin
                    chk("unexpected_tap", 1, 0);
                end else begin
                    chk("pix_addr", int'(bus.pix_addr), exp_pix.pop_front());
                    chk("wgt_addr", int'(bus.wgt_addr), exp_wgt.pop_front());
                end
                if (cur[1]) win_first.push_back(cyc);
                if (first_tap_cyc < 0) first_tap_cyc = cyc;
                last_tap_cyc = cyc;
                tap_cnt++;
            end

            if (prev_hold) chk("out_valid_held", int'(bus.out_valid), 1);
            if (bus.out_valid) begin
                if (exp_row.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("out_row", int'(bus.out_row), exp_row[0]);
                    chk("out_col", int'(bus.out_col), exp_col[0]);
                    if (bus.out_ready) begin
                        void'(exp_row.pop_front());
                        void'(exp_col.pop_front());
                        res_cnt++;
                    end
                end
                if (!bus.out_ready) hold_cnt++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;

            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                cfg_at_done = cfg_err;
                chk("done_all_consumed", exp_pix.size() + exp_row.size(), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic new_job(input int w, input int h);
        first_tap_cyc = -1;
        first_clr_cyc = -1;
        last_tap_cyc  = -1;
        last_accl_cyc = -1;
        tap_cnt       = 0;
        res_cnt       = 0;
        hold_cnt      = 0;
        win_first.delete();
        if (w >= K && h >= K && w * h <= 4096) build_job(w, h);
        img_w     = DIM_W'(w);
        img_h     = DIM_W'(h);
        start     = 1'b1;
        start_cyc = cyc;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick(1);
            i++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int dn;
        int s;
        done_cnt      = 0;
        bus.out_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // 6x6, no backpressure; model pinned against hand-derived values.
        new_job(6, 6);
        chk("model_pix5", exp_pix[5], 6);
        chk("model_pix24", exp_pix[24], 28);
        chk("model_nresults", exp_row.size(), 4);
        chk("model_win1", exp_row[1] * 10 + exp_col[1], 1);
        chk("model_win3", exp_row[3] * 10 + exp_col[3], 11);
        wait_done(200);
        chk("6x6_first_tap", first_tap_cyc - start_cyc, 1);
        chk("6x6_done_cycle", done_cyc - start_cyc, 113);
        chk("6x6_results", res_cnt, 4);
        chk("6x6_taps", tap_cnt, 100);
        chk("6x6_cfg_err", int'(cfg_at_done), 0);
        chk("6x6_busy_after", int'(busy), 0);

        // 5x5: single window, strobe alignment.
        tick(2);
        new_job(5, 5);
        bad = 0;
        for (int i = 0; i < 25; i++) if (exp_pix[i] != i) bad++;
        chk("model_5x5_pix", bad, 0);
        wait_done(100);
        chk("5x5_first_tap", first_tap_cyc - start_cyc, 1);
        chk("5x5_clr_delay", first_clr_cyc - first_tap_cyc, 2);
        chk("5x5_last_delay", last_accl_cyc - last_tap_cyc, 2);
        chk("5x5_done_cycle", done_cyc - start_cyc, 29);
        chk("5x5_taps", tap_cnt, 25);
        chk("5x5_results", res_cnt, 1);

        // Backpressure on window (0,1) for 10 cycles.
        tick(2);
        new_job(6, 6);
        while (cyc < start_cyc + 55) tick(1);
        bus.out_ready = 1'b0;
        tick(11);
        bus.out_ready = 1'b1;
        wait_done(300);
        chk("bp_hold_cycles", hold_cnt, 10);
        chk("bp_win2_first_tap", (win_first.size() > 2) ? win_first[2] - start_cyc : -1, 67);
        chk("bp_done_cycle", done_cyc - start_cyc, 123);
        chk("bp_results", res_cnt, 4);

        // Config errors, then a valid start clears cfg_err.
        tick(2);
        new_job(4, 8);
        wait_done(20);
        chk("err_w_done_cycle", done_cyc - start_cyc, 1);
        chk("err_w_cfg_err", int'(cfg_at_done), 1);
        chk("err_w_taps", tap_cnt, 0);
        tick(2);
        chk("err_sticky", int'(cfg_err), 1);
        new_job(205, 20);
        wait_done(20);
        chk("err_area_done_cycle", done_cyc - start_cyc, 1);
        chk("err_area_cfg_err", int'(cfg_at_done), 1);
        tick(1);
        new_job(5, 5);
        chk("err_cleared", int'(cfg_err), 0);
        wait_done(100);
        chk("err_then_ok_done", done_cyc - start_cyc, 29);
        chk("err_then_ok_cfg", int'(cfg_at_done), 0);

        // Stray starts mid-job and on the final handshake.
        tick(2);
        new_job(6, 6);
        s = start_cyc;
        while (cyc < s + 40) tick(1);
        img_w = 8'd5;
        img_h = 8'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        while (cyc < s + 112) tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(50);
        chk("stray_done_cycle", done_cyc - s, 113);
        chk("stray_results", res_cnt, 4);
        dn = done_cnt;
        tick(5);
        chk("stray_no_restart_busy", int'(busy), 0);
        chk("stray_no_extra_taps", tap_cnt, 100);
        chk("stray_no_extra_done", done_cnt - dn, 0);

        // Reset during ISSUE of window 2, then a fresh job.
        tick(2);
        new_job(6, 6);
        s = start_cyc;
        while (cyc < s + 60) tick(1);
        dn    = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("reset_async_tap", int'(bus.tap_valid), 0);
        chk("reset_async_busy", int'(busy), 0);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("reset_no_done", done_cnt - dn, 0);
        new_job(6, 6);
        wait_done(200);
        chk("post_reset_done_cycle", done_cyc - start_cyc, 113);
        chk("post_reset_results", res_cnt, 4);
        chk("post_reset_taps", tap_cnt, 100);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pe_conv_sched.md
Name: pe_conv_sched

Overview:
Sequencer for one 5x5 convolution PE. It walks every valid output position of an image held in a pixel buffer. For each window it issues KNL_SIZE*KNL_SIZE operand-read addresses, one per cycle, to the pixel and weight buffers. It also generates accumulator clear, enable and last strobes aligned to the memory-read plus multiplier pipeline, and presents each finished window result to downstream logic through a valid/ready handshake.

Parameters:
KNL_SIZE, 5, kernel edge length (taps per window = KNL_SIZE^2)
DIM_W, 8, width of image dimension inputs
ADDR_W, 12, pixel-buffer address width
WADDR_W, 5, weight-buffer address width (must hold KNL_SIZE^2-1)
PIPE_LAT, 2, cycles from tap issue to product at accumulator input (1 read + 1 multiply)

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  one-cycle job start pulse, sampled only in IDLE
img_w  in  DIM_W  image width, latched on accepted start
img_h  in  DIM_W  image height, latched on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle job-complete pulse
cfg_err  out  1  set with done when the config is rejected; cleared on next accepted start
tap_valid  out  1  pix_addr/wgt_addr valid this cycle
pix_addr  out  ADDR_W  pixel-buffer read address
wgt_addr  out  WADDR_W  weight-buffer read address
acc_clr  out  1  accumulator loads the product instead of adding (first tap, delayed)
acc_en  out  1  accumulator consumes the product (delayed tap_valid)
acc_last  out  1  final tap of the window (delayed)
out_valid  out  1  PE result register holds a complete window
out_ready  in  1  downstream accepts the result
out_row  out  DIM_W  output row of the presented result
out_col  out  DIM_W  output column of the presented result

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, FSM goes to IDLE and every output is 0, including counters and the delay line. Reset mid-job abandons the job; no done is issued.
- FSM states: IDLE, ISSUE, DRAIN, WAIT_OUT, FIN.
- IDLE:
  - start=1 latches img_w and img_h.
  - If img_w<KNL_SIZE, img_h<KNL_SIZE, or img_w*img_h>2^ADDR_W, go to FIN with cfg_err=1. No taps are issued.
  - Otherwise go to ISSUE. orow, ocol, kr and kc all start at 0.
- ISSUE:
  - tap_valid=1 every cycle.
  - pix_addr = (orow+kr)*img_w + ocol + kc. Compute it with an additive row base; no multiplier.
  - wgt_addr = kr*KNL_SIZE + kc.
  - kc counts 0..K-1, then wraps and increments kr.
  - After tap (K-1,K-1), go to DRAIN.
- Delay line: acc_en, acc_clr (tap 0) and acc_last (tap K^2-1) equal tap_valid, first-tap and last-tap delayed exactly PIPE_LAT cycles.
- DRAIN: stays PIPE_LAT cycles, so acc_last has fired. Then go to WAIT_OUT.
- WAIT_OUT:
  - out_valid=1. out_row and out_col hold the window's orow and ocol.
  - out_valid stays stable until out_valid&&out_ready.
  - On handshake, advance ocol. On ocol=img_w-K, wrap to 0 and advance orow.
  - If the window was the last (orow=img_h-K, ocol=img_w-K), go to FIN. Otherwise return to ISSUE the next cycle.
  - No taps issue while waiting; backpressure stalls the whole schedule.
- FIN: done=1 for one cycle, busy=0 the same cycle, then IDLE.
- Timing with out_ready=1:
  - First tap issues 1 cycle after start.
  - Each window takes K^2+PIPE_LAT+1 cycles (28 with defaults).
  - done comes 1 cycle after the final handshake.
- Counts: outputs per job = (img_w-K+1)*(img_h-K+1).
- start while busy is ignored. start and the final handshake in the same cycle: start is ignored.
- Address arithmetic is unsigned. The config check guarantees no ADDR_W overflow.

Decomposition:
- Shared package pe_pkg holds:
  - KNL_SIZE default and PIPE_LAT default
  - state enum {IDLE, ISSUE, DRAIN, WAIT_OUT, FIN}
  - TAPS = KNL_SIZE*KNL_SIZE constant
- One sub-module, pe_strobe_delay: a parameterised PIPE_LAT-deep shift register carrying {en, clr, last}, with asynchronous reset to 0.

Test Plan:
- 6x6 image, out_ready=1:
  - first window pix_addr sequence 0,1,2,3,4,6,7,...,28; wgt_addr 0..24
  - 4 results in (row,col) order (0,0),(0,1),(1,0),(1,1)
  - first tap 1 cycle after start; done 1+4*28 cycles after start
- 5x5 image: exactly one window, 25 taps, pix_addr 0..24; acc_clr exactly 2 cycles after the first tap_valid; acc_last 2 cycles after the last; done at cycle 29.
- Backpressure, 6x6 image, out_ready held 0 for 10 cycles on window (0,1): out_valid, out_row=0, out_col=1 stay stable; tap_valid=0 throughout; resumes 1 cycle after ready.
- Config errors:
  - img_w=4, img_h=8: done and cfg_err in the cycle after start; zero tap_valid.
  - Next valid start clears cfg_err.
- start pulsed mid-job and in the final-handshake cycle: ignored; output count and done timing unchanged.
- rst_n asserted during ISSUE of window 2: all outputs 0 immediately; no done; a fresh start after release runs a full correct job.
